// File: rtl/ac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ac_pkg
//  Brief    : Shared state encodings and default timing constants for the
//             AC actuator sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ac_pkg;

    // Sequencer state encodings (3-bit, exposed on the debug state port)
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_HEAT    = 3'd1;
    localparam logic [2:0] c_ST_COOL    = 3'd2;
    localparam logic [2:0] c_ST_RUNON   = 3'd3;
    localparam logic [2:0] c_ST_LOCKOUT = 3'd4;

    // Default dwell times in clock cycles
    localparam logic [15:0] c_MIN_ON_DFLT  = 16'd8;
    localparam logic [15:0] c_RUNON_DFLT   = 16'd4;
    localparam logic [15:0] c_LOCKOUT_DFLT = 16'd10;

endpackage : ac_pkg
`default_nettype wire

// File: rtl/ac_actuator_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_counter
//  Brief    : 16-bit dwell counter. Clears on clr, otherwise increments and
//             holds at all-ones rather than wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module dwell_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    output logic [15:0] cnt
);

    logic [15:0] r_cnt;

    // Clear on request, else count up and saturate at 16'hFFFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (clr) begin
            r_cnt <= 16'd0;
        end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cnt = r_cnt;

endmodule : dwell_counter
`default_nettype wire

// File: rtl/ac_actuator.sv
`default_nettype none
// ============================================================================
//  Module   : ac_actuator
//  Brief    : Sequences heater, compressor and fan from heat/cool demands,
//             enforcing minimum on-time, fan run-on and compressor lockout.
//  Revision : 1.0 - initial release
// ============================================================================
module ac_actuator
    import ac_pkg::*;
#(
    parameter logic [15:0] MIN_ON  = c_MIN_ON_DFLT,
    parameter logic [15:0] RUNON   = c_RUNON_DFLT,
    parameter logic [15:0] LOCKOUT = c_LOCKOUT_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heat_req,
    input  logic       cool_req,
    output logic       heater_on,
    output logic       compressor_on,
    output logic       fan_on,
    output logic       conflict,
    output logic [2:0] state
);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_from_cool;
    logic        w_clr;
    logic [15:0] w_cnt;

    // The dwell count restarts whenever the state is about to change, so
    // every state sees count 0 in its first cycle.
    assign w_clr = (w_next != r_state);

    dwell_counter u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .cnt   (w_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember whether run-on followed cooling, which decides on lockout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_from_cool <= 1'b0;
        end else if (w_next == c_ST_RUNON) begin
            if (r_state == c_ST_COOL) begin
                r_from_cool <= 1'b1;
            end else if (r_state == c_ST_HEAT) begin
                r_from_cool <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (heat_req && !cool_req) begin
                    w_next = c_ST_HEAT;
                end else if (cool_req && !heat_req) begin
                    w_next = c_ST_COOL;
                end
            end
            c_ST_HEAT: begin
                if ((w_cnt >= (MIN_ON - 16'd1)) && (!heat_req || cool_req)) begin
                    w_next = c_ST_RUNON;
                end
            end
            c_ST_COOL: begin
                if ((w_cnt >= (MIN_ON - 16'd1)) && (!cool_req || heat_req)) begin
                    w_next = c_ST_RUNON;
                end
            end
            c_ST_RUNON: begin
                // Heating may resume straight out of a heat run-on; after
                // cooling the compressor must sit out the lockout first.
                if (!r_from_cool && heat_req && !cool_req) begin
                    w_next = c_ST_HEAT;
                end else if (w_cnt == (RUNON - 16'd1)) begin
                    w_next = r_from_cool ? c_ST_LOCKOUT : c_ST_IDLE;
                end
            end
            c_ST_LOCKOUT: begin
                if (w_cnt == (LOCKOUT - 16'd1)) begin
                    w_next = c_ST_IDLE;
                end
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    // Moore output decode; heater and compressor come from distinct states
    // so they can never be on together.
    always_comb begin
        heater_on     = 1'b0;
        compressor_on = 1'b0;
        fan_on        = 1'b0;
        case (r_state)
            c_ST_HEAT: begin
                heater_on = 1'b1;
                fan_on    = 1'b1;
            end
            c_ST_COOL: begin
                compressor_on = 1'b1;
                fan_on        = 1'b1;
            end
            c_ST_RUNON: begin
                fan_on = 1'b1;
            end
            default: begin
                heater_on     = 1'b0;
                compressor_on = 1'b0;
                fan_on        = 1'b0;
            end
        endcase
    end

    assign conflict = (r_state == c_ST_IDLE) && heat_req && cool_req;
    assign state    = r_state;

endmodule : ac_actuator
`default_nettype wire

// File: tb/tb_ac_actuator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ac_actuator
//  Brief    : Directed self-checking bench for ac_actuator (default timing).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ac_actuator;

    logic       clk;
    logic       rst_n;
    logic       heat_req;
    logic       cool_req;
    logic       heater_on;
    logic       compressor_on;
    logic       fan_on;
    logic       conflict;
    logic [2:0] state;

    int checks;
    int errors;

    // Expected {state, heater_on, compressor_on, fan_on}
    localparam logic [5:0] c_E_IDLE = 6'b000_000;
    localparam logic [5:0] c_E_HEAT = 6'b001_101;
    localparam logic [5:0] c_E_COOL = 6'b010_011;
    localparam logic [5:0] c_E_RUN  = 6'b011_001;
    localparam logic [5:0] c_E_LOCK = 6'b100_000;

    logic [5:0] w_obs;
    assign w_obs = {state, heater_on, compressor_on, fan_on};

    ac_actuator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .heat_req      (heat_req),
        .cool_req      (cool_req),
        .heater_on     (heater_on),
        .compressor_on (compressor_on),
        .fan_on        (fan_on),
        .conflict      (conflict),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; land 1 time unit after the posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        heat_req = 1'b0;
        cool_req = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        heat_req = 1'b1;
        cool_req = 1'b0;
        #3;
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", w_obs, c_E_IDLE);
        end
        step();
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL reset_edge: got %b expected %b", w_obs, c_E_IDLE);
        end
        heat_req = 1'b0;
        rst_n    = 1'b1;
        step();
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", w_obs, c_E_IDLE);
        end
    endtask

    task automatic test_heat_pulse();
        heat_req = 1'b1;
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL heat_latency: got %b expected %b", w_obs, c_E_IDLE);
        end
        step();
        heat_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_obs !== c_E_HEAT) begin
                errors++;
                $display("FAIL heat_on cyc %0d: got %b expected %b", i, w_obs, c_E_HEAT);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_obs !== c_E_RUN) begin
                errors++;
                $display("FAIL heat_runon cyc %0d: got %b expected %b", i, w_obs, c_E_RUN);
            end
            step();
        end
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL heat_idle: got %b expected %b", w_obs, c_E_IDLE);
        end
    endtask

    task automatic test_cool_lockout();
        cool_req = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (w_obs !== c_E_COOL) begin
                errors++;
                $display("FAIL cool_on cyc %0d: got %b expected %b", i, w_obs, c_E_COOL);
            end
            if (i == 19) cool_req = 1'b0;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_obs !== c_E_RUN) begin
                errors++;
                $display("FAIL cool_runon cyc %0d: got %b expected %b", i, w_obs, c_E_RUN);
            end
            step();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_obs !== c_E_LOCK) begin
                errors++;
                $display("FAIL lockout cyc %0d: got %b expected %b", i, w_obs, c_E_LOCK);
            end
            if (i == 2) cool_req = 1'b1;
            step();
        end
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL lockout_exit: got %b expected %b", w_obs, c_E_IDLE);
        end
        step();
        checks++;
        if (w_obs !== c_E_COOL) begin
            errors++;
            $display("FAIL cool_restart: got %b expected %b", w_obs, c_E_COOL);
        end
        do_reset();
    endtask

    task automatic test_conflict();
        heat_req = 1'b1;
        cool_req = 1'b1;
        #1;
        checks++;
        if (conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_flag: got %b expected 1", conflict);
        end
        step();
        step();
        checks++;
        if ({w_obs, conflict} !== {c_E_IDLE, 1'b1}) begin
            errors++;
            $display("FAIL conflict_hold: got %b expected %b", {w_obs, conflict}, {c_E_IDLE, 1'b1});
        end
        heat_req = 1'b0;
        #1;
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear: got %b expected 0", conflict);
        end
        cool_req = 1'b0;
        step();
    endtask

    task automatic test_heat_retrigger();
        heat_req = 1'b1;
        step();
        heat_req = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (w_obs !== c_E_RUN) begin
            errors++;
            $display("FAIL retrig_runon1: got %b expected %b", w_obs, c_E_RUN);
        end
        step();
        heat_req = 1'b1;
        checks++;
        if (w_obs !== c_E_RUN) begin
            errors++;
            $display("FAIL retrig_runon2: got %b expected %b", w_obs, c_E_RUN);
        end
        step();
        heat_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_obs !== c_E_HEAT) begin
                errors++;
                $display("FAIL retrig_heat cyc %0d: got %b expected %b", i, w_obs, c_E_HEAT);
            end
            step();
        end
        checks++;
        if (w_obs !== c_E_RUN) begin
            errors++;
            $display("FAIL retrig_end: got %b expected %b", w_obs, c_E_RUN);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        cool_req = 1'b1;
        step();
        step();
        step();
        checks++;
        if (w_obs !== c_E_COOL) begin
            errors++;
            $display("FAIL areset_pre: got %b expected %b", w_obs, c_E_COOL);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL areset_now: got %b expected %b", w_obs, c_E_IDLE);
        end
        cool_req = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL areset_after: got %b expected %b", w_obs, c_E_IDLE);
        end
    endtask

    task automatic test_heat_to_cool();
        heat_req = 1'b1;
        step();
        step();
        step();
        heat_req = 1'b0;
        cool_req = 1'b1;
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (w_obs !== c_E_HEAT) begin
                errors++;
                $display("FAIL h2c_heat cnt %0d: got %b expected %b", i, w_obs, c_E_HEAT);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_obs !== c_E_RUN) begin
                errors++;
                $display("FAIL h2c_runon cyc %0d: got %b expected %b", i, w_obs, c_E_RUN);
            end
            step();
        end
        checks++;
        if (w_obs !== c_E_IDLE) begin
            errors++;
            $display("FAIL h2c_idle: got %b expected %b", w_obs, c_E_IDLE);
        end
        step();
        checks++;
        if (w_obs !== c_E_COOL) begin
            errors++;
            $display("FAIL h2c_cool: got %b expected %b", w_obs, c_E_COOL);
        end
        do_reset();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        heat_req = 1'b0;
        cool_req = 1'b0;
        test_reset();
        test_heat_pulse();
        test_cool_lockout();
        test_conflict();
        test_heat_retrigger();
        test_async_reset();
        test_heat_to_cool();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ac_actuator
`default_nettype wire

// File: doc/ac_actuator.md
AC_ACTUATOR -- requirements
Module: ac_actuator

Interface
REQ-001 Parameter MIN_ON, default 16'd8, SHALL set the minimum cycles heater/compressor stay on once started (legal range 1..65535).
REQ-002 Parameter RUNON, default 16'd4, SHALL set the fan-only run-on cycles after heat/cool ends (legal range 1..65535).
REQ-003 Parameter LOCKOUT, default 16'd10, SHALL set the all-off compressor restart delay in cycles (legal range 1..65535).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the posedge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 heat_req  input  1  SHALL carry the heating demand from the upstream AC controller (its heating output).
REQ-007 cool_req  input  1  SHALL carry the cooling demand from the upstream AC controller (its cooling output).
REQ-008 heater_on  output  1  SHALL drive the heater element.
REQ-009 compressor_on  output  1  SHALL drive the cooling compressor.
REQ-010 fan_on  output  1  SHALL drive the air-circulation fan.
REQ-011 conflict  output  1  SHALL flag heat_req and cool_req both high in IDLE (combinational).
REQ-012 state  output  3  SHALL expose the current FSM state for debug.

Function
REQ-013 FSM states SHALL be IDLE=0, HEAT=1, COOL=2, RUNON=3, LOCKOUT=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-014 Outputs SHALL be Moore decodes of state: HEAT -> heater_on and fan_on; COOL -> compressor_on and fan_on; RUNON -> fan_on only; IDLE and LOCKOUT -> all off.
REQ-015 heater_on and compressor_on SHALL never be high in the same cycle.
REQ-016 A 16-bit dwell counter SHALL clear to 0 on every state change, increment each cycle otherwise, and saturate at 16'hFFFF.
REQ-017 IDLE: heat_req and not cool_req -> HEAT; cool_req and not heat_req -> COOL; both or neither -> stay IDLE.
REQ-018 HEAT: when count >= MIN_ON-1 and (heat_req low or cool_req high) -> RUNON; otherwise stay.
REQ-019 COOL: when count >= MIN_ON-1 and (cool_req low or heat_req high) -> RUNON; otherwise stay.
REQ-020 A registered from_cool flag SHALL be set on the COOL->RUNON transition and cleared on the HEAT->RUNON transition.
REQ-021 RUNON, from_cool=0: heat_req and not cool_req -> HEAT immediately.
REQ-022 RUNON, otherwise: at count == RUNON-1 -> LOCKOUT if from_cool, else IDLE.
REQ-023 LOCKOUT SHALL ignore both requests and go to IDLE at count == LOCKOUT-1.
REQ-024 Request-to-output latency SHALL be one clock: a request sampled at edge N drives outputs after edge N.
REQ-025 Minimum on-time SHALL be exactly MIN_ON cycles, run-on exactly RUNON cycles, and lockout exactly LOCKOUT cycles.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, count=0, from_cool=0 and all registered outputs low, including mid-HEAT, mid-COOL or mid-LOCKOUT.
REQ-027 After rst_n deasserts, the first transition SHALL occur no earlier than the first posedge at which rst_n is high.

Structure
REQ-028 Shared package ac_pkg SHALL hold the state encodings and the default MIN_ON, RUNON and LOCKOUT constants.
REQ-029 Sub-module dwell_counter SHALL implement the 16-bit clear/increment/saturate counter with clr input and cnt output.

Verification
REQ-030 heat_req pulsed high 1 cycle from IDLE -> heater_on high 8 cycles, fan_on high 12 cycles, then IDLE with all outputs low.
REQ-031 cool_req held 20 cycles then low, reasserted during lockout -> compressor_on 20 cycles, fan_on 24 cycles, 10 cycles all off, compressor_on again 1 cycle after lockout ends.
REQ-032 heat_req=cool_req=1 in IDLE -> conflict=1, state stays 0, all actuator outputs low.
REQ-033 heat_req dropped, then reasserted in RUNON cycle 2 -> state=HEAT next cycle, fan_on continuous, heater_on restarts a fresh 8-cycle minimum.
REQ-034 rst_n pulled low in COOL cycle 3 -> compressor_on and fan_on low without a clock edge; state=0 after release.
REQ-035 cool_req rises in HEAT at count 2 -> heater stays on to count 7, then RUNON 4 cycles, IDLE, COOL with no lockout.
